// File: rtl/complex_sync_fifo.sv
// Single-clock FIFO for complex I/Q samples (I in the upper half of each
// word, Q in the lower half). Provides a fill level, programmable
// almost-full/almost-empty flags, a read-valid strobe, sticky
// overflow/underflow flags and a synchronous flush.
module complex_sync_fifo #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      wr_en_i,
  input  logic [2*DATA_WIDTH-1:0]   wr_data_i,
  input  logic                      rd_en_i,
  output logic [2*DATA_WIDTH-1:0]   rd_data_o,
  output logic                      rd_valid_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  output logic [ADDR_WIDTH:0]       level_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int WORD_WIDTH = 2 * DATA_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  // Thresholds brought to the level width so the flag compares are exact.
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // The extra MSB on each pointer tells a full FIFO from an empty one.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] level_next;

  logic wr_acc;
  logic rd_acc;

  // Acceptance uses the registered flags; a flush cancels both requests.
  assign wr_acc = wr_en_i & ~full_o  & ~clear_i;
  assign rd_acc = rd_en_i & ~empty_o & ~clear_i;

  // Next-state fill level; the registered flags are derived from it.
  always_comb begin
    // NOTE: assign a default first so every path drives level_next and no latch is inferred.
    level_next = level_o;
    if (clear_i) begin
      level_next = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   level_next = level_o + 1'b1;
        2'b01:   level_next = level_o - 1'b1;
        default: level_next = level_o;
      endcase
    end
  end

  // Write port of the simple dual-port RAM.
  // NOTE: storage has no reset so it can map onto block RAM; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i;
    end
  end

  // Pointers, level, status flags, registered read data and sticky errors.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      rd_data_o      <= '0;
      rd_valid_o     <= 1'b0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      level_o        <= level_next;
      full_o         <= (level_next == DEPTH_LVL);
      empty_o        <= (level_next == '0);
      almost_full_o  <= (level_next >= AFULL_LVL);
      almost_empty_o <= (level_next <= AEMPTY_LVL);
      rd_valid_o     <= rd_acc;

      if (clear_i) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_acc) begin
          rd_ptr    <= rd_ptr + 1'b1;
          rd_data_o <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
        if (wr_en_i && full_o) begin
          overflow_o <= 1'b1;
        end
        if (rd_en_i && empty_o) begin
          underflow_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_complex_sync_fifo.sv
// Self-checking bench for complex_sync_fifo (DEPTH=16, thresholds 12/2).
// A queue holds the words the FIFO should contain; writes push onto it,
// accepted reads pop the word the DUT must present one cycle later.
module tb_complex_sync_fifo;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int AET   = 2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            clear_i = 1'b0;
  logic            wr_en_i = 1'b0;
  logic [2*DW-1:0] wr_data_i = '0;
  logic            rd_en_i = 1'b0;
  logic [2*DW-1:0] rd_data_o;
  logic            rd_valid_o;
  logic            full_o;
  logic            empty_o;
  logic            almost_full_o;
  logic            almost_empty_o;
  logic [AW:0]     level_o;
  logic            overflow_o;
  logic            underflow_o;

  complex_sync_fifo #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .AFULL_THRESH (AFT),
    .AEMPTY_THRESH(AET)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .wr_en_i       (wr_en_i),
    .wr_data_i     (wr_data_i),
    .rd_en_i       (rd_en_i),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o),
    .level_o       (level_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference state.
  logic [2*DW-1:0] sb[$];
  logic [2*DW-1:0] exp_data  = '0;
  logic            exp_valid = 1'b0;
  logic            exp_ovf   = 1'b0;
  logic            exp_unf   = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = sb.size();
    check("rd_valid",     rd_valid_o,     exp_valid);
    check("rd_data",      rd_data_o,      exp_data);
    check("level",        level_o,        lvl);
    check("full",         full_o,         lvl == DEPTH);
    check("empty",        empty_o,        lvl == 0);
    check("almost_full",  almost_full_o,  lvl >= AFT);
    check("almost_empty", almost_empty_o, lvl <= AET);
    check("overflow",     overflow_o,     exp_ovf);
    check("underflow",    underflow_o,    exp_unf);
  endtask

  // One clock cycle of stimulus, then update the reference and compare.
  task automatic step(input logic wr, input logic [2*DW-1:0] d, input logic rd, input logic clr);
    logic was_full, was_empty;
    wr_en_i   = wr;
    wr_data_i = d;
    rd_en_i   = rd;
    clear_i   = clr;
    was_full  = (sb.size() == DEPTH);
    was_empty = (sb.size() == 0);
    @(posedge clk_i);
    #1;
    exp_valid = 1'b0;
    if (clr) begin
      sb.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (wr && was_full)  exp_ovf = 1'b1;
      if (rd && was_empty) exp_unf = 1'b1;
      if (rd && !was_empty) begin
        exp_data  = sb.pop_front();
        exp_valid = 1'b1;
      end
      if (wr && !was_full) sb.push_back(d);
    end
    check_outputs();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  initial begin
    // Power-on reset, checked before any clock edge has seen it.
    #2 rst_i = 1'b1;
    #2;
    model_reset();
    check_outputs();
    #8 rst_i = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Fill to full, then one dropped write.
    for (int n = 0; n < 16; n++) step(1'b1, 32'h0001_0000 + n, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Drain in order, then one read from empty.
    for (int n = 0; n < 16; n++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Clear the sticky flags, fill to 8, then stream 40 cycles of read+write.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 8; n++) step(1'b1, 32'h2000_0000 + n, 1'b0, 1'b0);
    for (int n = 8; n < 48; n++) step(1'b1, 32'h2000_0000 + n, 1'b1, 1'b0);

    // Full: read wins, write rejected.
    for (int n = 0; n < 8; n++) step(1'b1, 32'h3000_0000 + n, 1'b0, 1'b0);
    step(1'b1, 32'h3BAD_0000, 1'b1, 1'b0);
    // Empty: write wins, read rejected.
    for (int n = 0; n < 15; n++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h4000_0001, 1'b1, 1'b0);

    // Reach level 5 with overflow set, then flush together with a write.
    for (int n = 0; n < 15; n++) step(1'b1, 32'h5000_0000 + n, 1'b0, 1'b0);
    step(1'b1, 32'h5BAD_0000, 1'b0, 1'b0);
    for (int n = 0; n < 11; n++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h6666_6666, 1'b0, 1'b1);
    step(1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream at level 9.
    for (int n = 0; n < 9; n++) step(1'b1, 32'h7000_0000 + n, 1'b0, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #3 rst_i = 1'b0;
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/complex_sync_fifo.md
Name: complex_sync_fifo

Overview:
- Single-clock, parametrised-depth FIFO for complex I/Q samples. Packs I in the upper half of each word and Q in the lower half.
- Successor to the dual-clock I/Q FIFO, used where producer and consumer share one clock, e.g. between the LVDS deserialiser and the SPI/SMI streaming path.
- Adds features the previous block lacks:
  - full usable depth of 2^ADDR_WIDTH entries;
  - fill-level output;
  - programmable almost-full/almost-empty flags;
  - read-valid strobe;
  - sticky overflow/underflow error flags;
  - synchronous flush.

Parameters:
- ADDR_WIDTH, 8, log2 of depth; DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 16, width of each of I and Q; stored word is 2*DATA_WIDTH bits.
- AFULL_THRESH, 2^ADDR_WIDTH-4, almost_full_o asserts when level >= this value.
- AEMPTY_THRESH, 4, almost_empty_o asserts when level <= this value.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous flush: empties the FIFO and clears the error flags.
- wr_en_i  in  1  write request.
- wr_data_i  in  2*DATA_WIDTH  write word; [2*DW-1:DW] = I, [DW-1:0] = Q.
- rd_en_i  in  1  read request.
- rd_data_o  out  2*DATA_WIDTH  read word, registered.
- rd_valid_o  out  1  one-cycle strobe: rd_data_o holds newly read data.
- full_o  out  1  level == DEPTH.
- empty_o  out  1  level == 0.
- almost_full_o  out  1  level >= AFULL_THRESH.
- almost_empty_o  out  1  level <= AEMPTY_THRESH.
- level_o  out  ADDR_WIDTH+1  current number of stored entries, 0..DEPTH.
- overflow_o  out  1  sticky: a write was attempted while full.
- underflow_o  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous, rst_i=1) sets:
  - pointers = 0, level_o = 0;
  - empty_o = 1, almost_empty_o = 1;
  - full_o = 0, almost_full_o = 0;
  - rd_data_o = 0, rd_valid_o = 0;
  - overflow_o = 0, underflow_o = 0.
  Memory contents are not reset. Deassertion is used synchronously downstream; no data is accepted on the cycle rst_i is high.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB disambiguates full from empty.
  - Memory is addressed by the low ADDR_WIDTH bits.
  - Wrap-around is natural modulo 2^(ADDR_WIDTH+1).
- Write acceptance:
  - wr_acc = wr_en_i & ~full_o. The word is stored at wr_ptr and wr_ptr increments.
  - wr_en_i while full_o: the word is dropped, wr_ptr holds, overflow_o sets the next cycle.
  - A write while full is rejected even if a read occurs in the same cycle.
- Read acceptance:
  - rd_acc = rd_en_i & ~empty_o. rd_data_o <= mem[rd_ptr], rd_ptr increments, rd_valid_o = 1 the next cycle.
  - Read latency is 1 cycle.
  - rd_en_i while empty_o: rd_data_o holds, rd_valid_o = 0, underflow_o sets.
  - A read while empty is rejected even if a write occurs in the same cycle; there is no fall-through.
- Level update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both, or neither: unchanged.
- Flags:
  - full_o, empty_o, almost_full_o and almost_empty_o are registered.
  - They are computed from the next-state level, so they reflect level_o in the same cycle with no extra lag.
- rd_data_o holds its last value when no read is accepted.
- Simultaneous read and write at level 0 < L < DEPTH: both are accepted, level stays L, and the read returns the oldest entry, not the word being written.
- clear_i:
  - Next cycle: pointers = 0, level = 0, flags as at reset, overflow_o/underflow_o = 0, rd_valid_o = 0.
  - A write or read in the same cycle as clear_i is ignored.
  - clear_i overrides everything except rst_i.
- Error flags stay set until rst_i or clear_i.
- Memory is inferred as a simple dual-port RAM, one write port and one registered read port, mapping to SB_RAM40_4K blocks. DATA_WIDTH=16 with ADDR_WIDTH=8 uses two blocks.

Test Plan:
Common setup for all scenarios: ADDR_WIDTH=4 (DEPTH=16), DATA_WIDTH=16, AFULL_THRESH=12, AEMPTY_THRESH=2.
- Reset then idle → level_o=0, empty_o=1, almost_empty_o=1, full_o=0, rd_data_o=0, error flags=0. Assert rst_i mid-stream at level 9 → all outputs return to reset values immediately, without waiting for a clock edge.
- Write 16 words 0x00010000+n (n=0..15) back-to-back:
  - almost_empty_o drops after the 3rd write;
  - almost_full_o rises after the 12th;
  - full_o=1 and level_o=16 after the 16th;
  - 17th write (0xDEADBEEF) → dropped, overflow_o=1, level_o stays 16.
- Then read 16 words → rd_valid_o high 1 cycle after each rd_en_i, data 0x00010000..0x0001000F in order, empty_o=1 after the last. A 17th read → underflow_o=1, rd_valid_o=0, rd_data_o stays 0x0001000F.
- Fill to 8, then 40 cycles of simultaneous wr_en_i/rd_en_i with an incrementing pattern → level_o stays 8 throughout, output sequence continuous, and pointers wrap at least twice.
- At full, assert wr_en_i and rd_en_i together → read accepted, write rejected, level_o=15, overflow_o=1. At empty, assert both → write accepted, read rejected, level_o=1, underflow_o=1.
- With level 5 and overflow_o set, pulse clear_i together with wr_en_i → next cycle level_o=0, empty_o=1, overflow_o=0, and the written word is not stored: a subsequent write of 0xA5A55A5A is the next word read out.
